// File: rtl/ex_muldiv_seq.sv
// EX-stage sequencer: single-cycle ALU ops go straight to EX/MEM; MUL/DIV ops
// get a start pulse, hold the front of the pipe and wait for the unit's done flag.
module ex_muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int MAX_WAIT   = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_valid,
    input  logic [3:0]            i_alu_sel,
    input  logic [RD_WIDTH-1:0]   i_rd,
    input  logic                  i_reg_wen,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_done,
    output logic                  o_start_mul,
    output logic                  o_start_div,
    output logic                  o_stall,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [RD_WIDTH-1:0]   o_rd,
    output logic                  o_reg_wen,
    output logic                  o_timeout
);

    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  start_mul_q, start_mul_d;
    logic                  start_div_q, start_div_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  wen_q, wen_d;
    logic                  timeout_q, timeout_d;
    logic                  is_mul, is_div, is_ill;

    always_comb begin
        is_mul = (i_alu_sel == 4'b1010) || (i_alu_sel == 4'b1011);
        is_div = (i_alu_sel == 4'b1100) || (i_alu_sel == 4'b1101);
        is_ill = (i_alu_sel == 4'b1110) || (i_alu_sel == 4'b1111);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_mul_d = 1'b0;
        start_div_d = 1'b0;
        valid_d     = 1'b0;
        wen_d       = 1'b0;
        timeout_d   = 1'b0;
        result_d    = result_q;
        rd_d        = rd_q;
        o_stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid && !i_flush) begin
                    if (is_mul || is_div) begin
                        o_stall = 1'b1;
                        // A unit still busy from an aborted op must drain first.
                        if (i_alu_done) begin
                            state_d     = S_ISSUE;
                            start_mul_d = is_mul;
                            start_div_d = is_div;
                        end
                    end else begin
                        valid_d  = 1'b1;
                        result_d = i_alu_result;
                        rd_d     = i_rd;
                        wen_d    = i_reg_wen & ~is_ill;
                    end
                end
            end
            S_ISSUE: begin
                if (i_flush) state_d = S_IDLE;
                else begin
                    o_stall = 1'b1;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                // done is stale here: the unit only drops it the cycle after start.
                if (i_flush) state_d = S_IDLE;
                else begin
                    o_stall = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (i_alu_done) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b1;
                    result_d = i_alu_result;
                    rd_d     = i_rd;
                    wen_d    = i_reg_wen;
                end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    o_stall = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            start_mul_q <= 1'b0;
            start_div_q <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_mul_q <= start_mul_d;
            start_div_q <= start_div_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_start_mul = start_mul_q;
    assign o_start_div = start_div_q;
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_rd        = rd_q;
    assign o_reg_wen   = wen_q;
    assign o_timeout   = timeout_q;

endmodule
